w_stage_grf: RTL and testbench
==============================

Name: w_stage_grf

Overview:
- Write-back end of the M→W pipeline interface.
- Consumes the six W-stage pipeline signals (instr, dm, ALUresult, pc, HILO, cmpresult) and decodes the destination register.
- Selects and extends the write data, then commits it to the 32×32 general register file.
- Serves the D-stage read ports with write-through bypass, and exports the W-stage write tuple to the hazard/forwarding unit.

Parameters:
- NREG, 32, number of architectural registers; index width fixed at 5.
- DW, 32, data width.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears the register file.
- W_instr  in  32  instruction in W stage; 32'b0 = nop.
- W_dm  in  32  raw aligned data word read from DM.
- W_ALUresult  in  32  ALU result; for loads, the byte address.
- W_pc  in  32  PC of the W-stage instruction.
- W_HILO  in  32  HI or LO value selected in M stage.
- W_cmpresult  in  1  condition for conditional-write instructions.
- D_rs_addr  in  5  read address, port 1.
- D_rt_addr  in  5  read address, port 2.
- D_rd1  out  32  port-1 read data, combinational.
- D_rd2  out  32  port-2 read data, combinational.
- W_we  out  1  effective write enable this cycle.
- W_waddr  out  5  destination register; 0 when no write.
- W_wdata  out  32  final write data; 0 when no write.

Behaviour:
- Decode, classified by opcode and funct:
  - R-ALU (addu, subu, and, or, nor, xor, slt, sltu, sll, srl, sra, sllv, srlv, srav): dest rd, data ALUresult.
  - I-ALU (addiu, andi, ori, xori, lui, slti, sltiu): dest rt, data ALUresult.
  - Loads (lw, lh, lhu, lb, lbu): dest rt, data from load extension.
  - jal: dest 31, data W_pc+8.
  - jalr: dest rd, data W_pc+8.
  - mfhi / mflo: dest rd, data W_HILO.
  - movz (funct 0x0A) / movn (funct 0x0B): dest rd, data ALUresult, write only when W_cmpresult=1.
  - All others (stores, branches, j, mult/div, mthi/mtlo, nop): no write.
- Load extension, offset = ALUresult[1:0]:
  - lw: whole word.
  - lb / lbu: byte at offset, sign-/zero-extended.
  - lh / lhu: halfword at offset[1], sign-/zero-extended.
  - offset[0]=1 on a halfword access is not checked; it is treated as offset[1].
- W_we = class writes AND dest≠0 AND (not conditional OR W_cmpresult).
  - When W_we=0: W_waddr=0 and W_wdata=0.
- Write: at posedge clk, when W_we=1 and reset=0, regfile[W_waddr] ← W_wdata.
  - Exactly one write per cycle; latency 1 cycle to storage.
- Read: D_rdN = 0 if the address is 0.
  - Otherwise W_wdata if W_we=1 and the address equals W_waddr (write-through, same-cycle bypass).
  - Otherwise regfile[address].
  - Both ports may hit the bypass simultaneously.
- Reset:
  - At posedge with reset=1, all 31 storage registers ← 0; $0 is never stored.
  - Reset has priority over a pending write; that write is lost.
  - D_rd1/D_rd2 read 0 for all addresses from the cycle after reset.
- W_we/W_waddr/W_wdata are purely combinational from W inputs. With the upstream pipeline register in reset (instr=0), W_we=0.
- Writes to $0 are never visible on any port.

Decomposition:
- Shared package mips_defs:
  - Opcode and funct localparams: OP_RTYPE, OP_JAL, OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, ..., FN_JALR, FN_MFHI, FN_MFLO, FN_MOVZ, FN_MOVN.
  - Write-data-select enum WD_ALU/WD_DM/WD_PC8/WD_HILO.
  - Destination-select enum DST_RD/DST_RT/DST_RA.
- One natural sub-module: load_ext, combinational byte/half select and extend (inputs: word, offset, load type).
- Decode and regfile remain in w_stage_grf.

Test Plan:
- Reset, then read all 32 addresses → every value 0. Write addu rd=5 with ALUresult=0x1234 under reset=1 → $5 stays 0.
- ori rt=8, ALUresult=0x0000ABCD:
  - Same cycle, D_rs_addr=8 → D_rd1=0x0000ABCD via bypass.
  - Next cycle, instr=nop → D_rd1 still 0x0000ABCD from storage.
- lb rt=9, W_dm=0x80FF7F01:
  - ALUresult low bits 3 → 0xFFFFFF80; 1 → 0x0000007F.
  - lbu at 3 → 0x00000080.
  - lh at 2 → 0xFFFF80FF; lhu at 2 → 0x000080FF.
- jal with W_pc=0x00003000 → W_waddr=31, W_wdata=0x00003008. jalr rd=0 → W_we=0, $0 reads 0.
- movz rd=10, ALUresult=0x55:
  - W_cmpresult=0 → W_we=0, $10 unchanged.
  - W_cmpresult=1 → $10=0x55.
- mflo rd=4, W_HILO=0xDEADBEEF with D_rs_addr=D_rt_addr=4 → both D_rd1 and D_rd2 = 0xDEADBEEF in the same cycle. sw instruction → W_we=0.

Source files
------------

// File: rtl/w_stage_grf_pkg.sv
`default_nettype none
// mips_defs: opcode/funct encodings and W-stage decode select types.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MOVZ  = 6'h0A;
  localparam logic [5:0] FN_MOVN  = 6'h0B;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {WD_ALU, WD_DM, WD_PC8, WD_HILO} wd_sel_e;
  typedef enum logic [1:0] {DST_RD, DST_RT, DST_RA} dst_sel_e;
  typedef enum logic [2:0] {LD_W, LD_B, LD_BU, LD_H, LD_HU} ld_type_e;

endpackage
`default_nettype wire

// File: rtl/w_stage_grf_load_ext.sv
`default_nettype none
// load_ext: selects the addressed byte/halfword of a DM word and extends it.
module load_ext
  import mips_defs::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  ld_type_e    ld_type,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // An odd halfword offset is not trapped; only offset[1] picks the half.
  always_comb begin
    byte_v = word[8*offset +: 8];
    half_v = offset[1] ? word[31:16] : word[15:0];
    data   = word;
    case (ld_type)
      LD_B:    data = {{24{byte_v[7]}}, byte_v};
      LD_BU:   data = {24'b0, byte_v};
      LD_H:    data = {{16{half_v[15]}}, half_v};
      LD_HU:   data = {16'b0, half_v};
      default: data = word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/w_stage_grf.sv
`default_nettype none
// w_stage_grf: W-stage decode, write-data select and 32x32 register file
// with write-through bypass on both D-stage read ports.
module w_stage_grf
  import mips_defs::*;
#(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   W_instr,
  input  logic [DW-1:0] W_dm,
  input  logic [DW-1:0] W_ALUresult,
  input  logic [DW-1:0] W_pc,
  input  logic [DW-1:0] W_HILO,
  input  logic          W_cmpresult,
  input  logic [4:0]    D_rs_addr,
  input  logic [4:0]    D_rt_addr,
  output logic [DW-1:0] D_rd1,
  output logic [DW-1:0] D_rd2,
  output logic          W_we,
  output logic [4:0]    W_waddr,
  output logic [DW-1:0] W_wdata
);

  logic [5:0] opcode, funct;
  logic [4:0] rt, rd;
  assign opcode = W_instr[31:26];
  assign funct  = W_instr[5:0];
  assign rt     = W_instr[20:16];
  assign rd     = W_instr[15:11];
  wire unused_fields = &{1'b0, W_instr[25:21], W_instr[10:6]};

  logic     cls_writes, cond_write;
  dst_sel_e dst_sel;
  wd_sel_e  wd_sel;
  ld_type_e ld_type;

  always_comb begin
    cls_writes = 1'b0;
    cond_write = 1'b0;
    dst_sel    = DST_RD;
    wd_sel     = WD_ALU;
    ld_type    = LD_W;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_NOR, FN_XOR, FN_SLT, FN_SLTU,
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV:
            cls_writes = 1'b1;
          FN_JALR: begin
            cls_writes = 1'b1;
            wd_sel     = WD_PC8;
          end
          FN_MFHI, FN_MFLO: begin
            cls_writes = 1'b1;
            wd_sel     = WD_HILO;
          end
          FN_MOVZ, FN_MOVN: begin
            cls_writes = 1'b1;
            cond_write = 1'b1;
          end
          default: cls_writes = 1'b0;
        endcase
      end
      OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_SLTI, OP_SLTIU: begin
        cls_writes = 1'b1;
        dst_sel    = DST_RT;
      end
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
        cls_writes = 1'b1;
        dst_sel    = DST_RT;
        wd_sel     = WD_DM;
        case (opcode)
          OP_LB:   ld_type = LD_B;
          OP_LBU:  ld_type = LD_BU;
          OP_LH:   ld_type = LD_H;
          OP_LHU:  ld_type = LD_HU;
          default: ld_type = LD_W;
        endcase
      end
      OP_JAL: begin
        cls_writes = 1'b1;
        dst_sel    = DST_RA;
        wd_sel     = WD_PC8;
      end
      default: cls_writes = 1'b0;
    endcase
  end

  logic [DW-1:0] ld_data;
  load_ext u_load_ext (
    .word    (W_dm),
    .offset  (W_ALUresult[1:0]),
    .ld_type (ld_type),
    .data    (ld_data)
  );

  logic [4:0]    dest;
  logic [DW-1:0] sel_data;

  always_comb begin
    case (dst_sel)
      DST_RT:  dest = rt;
      DST_RA:  dest = REG_RA;
      default: dest = rd;
    endcase
    case (wd_sel)
      WD_DM:   sel_data = ld_data;
      WD_PC8:  sel_data = W_pc + DW'(8);
      WD_HILO: sel_data = W_HILO;
      default: sel_data = W_ALUresult;
    endcase
  end

  assign W_we    = cls_writes && (dest != 5'd0) && (!cond_write || W_cmpresult);
  assign W_waddr = W_we ? dest : 5'd0;
  assign W_wdata = W_we ? sel_data : '0;

  // $0 has no storage; index 0 is never written or read from the array.
  logic [DW-1:0] regs [1:NREG-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NREG; i++) regs[i] <= '0;
    end else if (W_we) begin
      regs[W_waddr] <= W_wdata;
    end
  end

  logic [4:0]    rd_addr [2];
  logic [DW-1:0] rd_data [2];
  assign rd_addr[0] = D_rs_addr;
  assign rd_addr[1] = D_rt_addr;

  for (genvar p = 0; p < 2; p++) begin : g_rd_port
    always_comb begin
      if (rd_addr[p] == 5'd0)
        rd_data[p] = '0;
      else if (W_we && rd_addr[p] == W_waddr)
        rd_data[p] = W_wdata;
      else
        rd_data[p] = regs[rd_addr[p]];
    end
  end

  assign D_rd1 = rd_data[0];
  assign D_rd2 = rd_data[1];

endmodule
`default_nettype wire

// File: tb/tb_w_stage_grf.sv
`default_nettype none
// tb_w_stage_grf: directed + random checks of w_stage_grf against a behavioural model.
module tb_w_stage_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] W_instr, W_dm, W_ALUresult, W_pc, W_HILO;
  logic        W_cmpresult;
  logic [4:0]  D_rs_addr, D_rt_addr;
  logic [31:0] D_rd1, D_rd2, W_wdata;
  logic        W_we;
  logic [4:0]  W_waddr;

  always #5 clk = ~clk;

  w_stage_grf dut (
    .clk(clk), .reset(reset), .W_instr(W_instr), .W_dm(W_dm),
    .W_ALUresult(W_ALUresult), .W_pc(W_pc), .W_HILO(W_HILO),
    .W_cmpresult(W_cmpresult), .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
    .D_rd1(D_rd1), .D_rd2(D_rd2), .W_we(W_we), .W_waddr(W_waddr), .W_wdata(W_wdata)
  );

  logic [31:0] mregs [32];
  int          vectors = 0;
  int          miscompares = 0;
  logic        exp_we;
  logic [4:0]  exp_wa;
  logic [31:0] exp_wd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, 5'd0, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
    return {op, 5'd0, rt, imm};
  endfunction

  // Reference: what architectural write does this W-stage bundle produce?
  task automatic model(input logic [31:0] ins, dm, alu, pc, hilo, input logic cmp);
    logic [5:0]  op, fn;
    logic [31:0] b, h;
    logic        writes, cond;
    op = ins[31:26]; fn = ins[5:0];
    b = (dm >> (8 * int'(alu[1:0]))) & 32'hFF;
    h = (dm >> (16 * int'(alu[1]))) & 32'hFFFF;
    writes = 1'b1; cond = 1'b0; exp_wa = ins[15:11]; exp_wd = alu;
    if (op == 6'h00) begin
      if (fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                     6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07}) exp_wd = alu;
      else if (fn == 6'h09) exp_wd = pc + 8;
      else if (fn == 6'h10 || fn == 6'h12) exp_wd = hilo;
      else if (fn == 6'h0A || fn == 6'h0B) cond = 1'b1;
      else writes = 1'b0;
    end else if (op inside {6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F}) begin
      exp_wa = ins[20:16];
    end else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
      exp_wa = ins[20:16];
      case (op)
        6'h20:   exp_wd = (b ^ 32'h80) - 32'h80;
        6'h24:   exp_wd = b;
        6'h21:   exp_wd = (h ^ 32'h8000) - 32'h8000;
        6'h25:   exp_wd = h;
        default: exp_wd = dm;
      endcase
    end else if (op == 6'h03) begin
      exp_wa = 31; exp_wd = pc + 8;
    end else begin
      writes = 1'b0;
    end
    exp_we = writes && exp_wa != 0 && (!cond || cmp);
    if (!exp_we) begin exp_wa = 0; exp_wd = 0; end
  endtask

  function automatic logic [31:0] rd_exp(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (exp_we && a == exp_wa) return exp_wd;
    return mregs[a];
  endfunction

  task automatic drive(input logic rst, input logic [31:0] ins, dm, alu, pc, hilo,
                       input logic cmp, input logic [4:0] a1, a2);
    reset = rst; W_instr = ins; W_dm = dm; W_ALUresult = alu; W_pc = pc;
    W_HILO = hilo; W_cmpresult = cmp; D_rs_addr = a1; D_rt_addr = a2;
    #2;
    model(ins, dm, alu, pc, hilo, cmp);
    check("we", {31'b0, W_we}, {31'b0, exp_we});
    check("waddr", {27'b0, W_waddr}, {27'b0, exp_wa});
    check("wdata", W_wdata, exp_wd);
    check("rd1", D_rd1, rd_exp(a1));
    check("rd2", D_rd2, rd_exp(a2));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) for (int i = 0; i < 32; i++) mregs[i] = 0;
    else if (exp_we) mregs[exp_wa] = exp_wd;
    #1;
  endtask

  task automatic nop_read(input logic [4:0] a1, a2);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, a1, a2);
  endtask

  logic [5:0] r_fns [16] = '{6'h21, 6'h23, 6'h24, 6'h27, 6'h2A, 6'h00, 6'h07, 6'h09,
                             6'h10, 6'h12, 6'h0A, 6'h0B, 6'h18, 6'h11, 6'h08, 6'h1A};
  logic [5:0] i_ops [16] = '{6'h09, 6'h0D, 6'h0F, 6'h0B, 6'h20, 6'h21, 6'h23, 6'h24,
                             6'h25, 6'h2B, 6'h29, 6'h04, 6'h02, 6'h0E, 6'h28, 6'h3F};

  initial begin
    logic [31:0] ins;
    logic [4:0]  a1, a2;
    reset = 1'b1; W_instr = 0; W_dm = 0; W_ALUresult = 0; W_pc = 0; W_HILO = 0;
    W_cmpresult = 0; D_rs_addr = 0; D_rt_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) mregs[i] = 0;

    for (int a = 0; a < 32; a++) begin
      nop_read(5'(a), 5'(31 - a));
      check("rst_rd1", D_rd1, 32'h0);
      tick();
    end

    drive(1'b1, rtype(5'd0, 5'd5, 6'h21), 0, 32'h1234, 0, 0, 1'b0, 5'd5, 5'd0);
    tick();
    nop_read(5'd5, 5'd0);
    check("rst_prio", D_rd1, 32'h0);
    tick();

    drive(1'b0, itype(6'h0D, 5'd8, 16'hABCD), 0, 32'h0000ABCD, 0, 0, 1'b0, 5'd8, 5'd0);
    check("ori_bypass", D_rd1, 32'h0000ABCD);
    tick();
    nop_read(5'd8, 5'd0);
    check("ori_stored", D_rd1, 32'h0000ABCD);
    tick();

    drive(1'b0, itype(6'h20, 5'd9, 16'h0), 32'h80FF7F01, 32'h3, 0, 0, 1'b0, 5'd9, 5'd0);
    check("lb3", W_wdata, 32'hFFFFFF80);
    tick();
    drive(1'b0, itype(6'h20, 5'd9, 16'h0), 32'h80FF7F01, 32'h1, 0, 0, 1'b0, 5'd9, 5'd0);
    check("lb1", W_wdata, 32'h0000007F);
    tick();
    drive(1'b0, itype(6'h24, 5'd9, 16'h0), 32'h80FF7F01, 32'h3, 0, 0, 1'b0, 5'd9, 5'd0);
    check("lbu3", W_wdata, 32'h00000080);
    tick();
    drive(1'b0, itype(6'h21, 5'd9, 16'h0), 32'h80FF7F01, 32'h2, 0, 0, 1'b0, 5'd9, 5'd0);
    check("lh2", W_wdata, 32'hFFFF80FF);
    tick();
    drive(1'b0, itype(6'h25, 5'd9, 16'h0), 32'h80FF7F01, 32'h2, 0, 0, 1'b0, 5'd9, 5'd0);
    check("lhu2", W_wdata, 32'h000080FF);
    tick();

    drive(1'b0, {6'h03, 26'h0}, 0, 0, 32'h00003000, 0, 1'b0, 5'd31, 5'd0);
    check("jal_waddr", {27'b0, W_waddr}, 32'd31);
    check("jal_wdata", W_wdata, 32'h00003008);
    tick();
    drive(1'b0, rtype(5'd0, 5'd0, 6'h09), 0, 0, 32'h00003000, 0, 1'b0, 5'd0, 5'd0);
    check("jalr0_we", {31'b0, W_we}, 32'h0);
    check("jalr0_rd", D_rd1, 32'h0);
    tick();

    drive(1'b0, rtype(5'd0, 5'd10, 6'h0A), 0, 32'h55, 0, 0, 1'b0, 5'd10, 5'd0);
    check("movz0_we", {31'b0, W_we}, 32'h0);
    tick();
    nop_read(5'd10, 5'd0);
    check("movz0_keep", D_rd1, 32'h0);
    tick();
    drive(1'b0, rtype(5'd0, 5'd10, 6'h0A), 0, 32'h55, 0, 0, 1'b1, 5'd0, 5'd0);
    tick();
    nop_read(5'd10, 5'd0);
    check("movz1", D_rd1, 32'h55);
    tick();

    drive(1'b0, rtype(5'd0, 5'd4, 6'h12), 0, 0, 0, 32'hDEADBEEF, 1'b0, 5'd4, 5'd4);
    check("mflo_rd1", D_rd1, 32'hDEADBEEF);
    check("mflo_rd2", D_rd2, 32'hDEADBEEF);
    tick();
    drive(1'b0, itype(6'h2B, 5'd7, 16'h4), 32'h1, 32'h4, 0, 0, 1'b0, 5'd7, 5'd0);
    check("sw_we", {31'b0, W_we}, 32'h0);
    tick();

    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 4))
        0, 1: ins = {6'h00, 5'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom), r_fns[$urandom_range(0, 15)]};
        2:    ins = {i_ops[$urandom_range(0, 15)], 5'($urandom), 5'($urandom_range(0, 7)), 16'($urandom)};
        3:    ins = {6'h03, 26'($urandom)};
        default: ins = $urandom;
      endcase
      a1 = 5'($urandom_range(0, 8)); if (a1 == 8) a1 = 31;
      a2 = 5'($urandom_range(0, 8)); if (a2 == 8) a2 = 31;
      drive($urandom_range(0, 49) == 0, ins, $urandom, $urandom, $urandom, $urandom,
            1'($urandom), a1, a2);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
